// File: rtl/mmio_bus_ctrl.sv
// mmio_bus_ctrl: registered MMIO bus controller routing CPU memory-stage accesses to RAM, serial and VGA.
// Optional VGA handshake timeout is compiled in when MMIO_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module mmio_bus_ctrl #(
   parameter int unsigned       ADDR_W        = 16,
   parameter int unsigned       DATA_W        = 16,
   parameter logic [ADDR_W-1:0] SER_DATA_ADDR = 16'hBF00,
   parameter logic [ADDR_W-1:0] SER_STAT_ADDR = 16'hBF01,
   parameter logic [ADDR_W-1:0] VGA_BASE      = 16'hBE00,
   parameter int unsigned       VGA_AW        = 4,
   parameter int unsigned       RAM_WAIT      = 1,
   parameter int unsigned       TIMEOUT       = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_i,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [DATA_W-1:0] wdata_i,
   output logic [DATA_W-1:0] rdata_o,
   output logic              ack_o,
   output logic              busy_o,
   output logic              err_o,
   output logic              ram_enable_o,
   output logic              ram_readWrite_o,
   output logic [ADDR_W-1:0] ram_address_o,
   output logic [DATA_W-1:0] ram_dataWrite_o,
   input  logic [DATA_W-1:0] ram_dataRead_i,
   output logic              serial_enable_o,
   output logic              serial_readWrite_o,
   output logic              serial_fetch_data_o,
   output logic [7:0]        serial_dataWrite_o,
   input  logic [7:0]        serial_dataRead_i,
   input  logic              serial_sendComplete_i,
   input  logic              serial_receiveComplete_i,
   output logic              vga_enable_o,
   output logic              vga_readWrite_o,
   output logic [VGA_AW-1:0] vga_address_o,
   output logic [DATA_W-1:0] vga_dataWrite_o,
   input  logic [DATA_W-1:0] vga_dataRead_i,
   input  logic              vga_ready_i
);

   // state        | meaning
   // S_IDLE       | waiting for req_i, nothing driven
   // S_RAM_SETUP  | RAM enabled, address/data settle, write strobe held off
   // S_RAM_ACCESS | RAM_WAIT+1 cycles with write strobe = we; read sampled in last cycle
   // S_SER        | one-cycle serial data/status access
   // S_VGA        | VGA strobe held until vga_ready_i (or timeout)
   // S_DONE       | ack_o pulse, all strobes low

   typedef enum logic [2:0] {
      S_IDLE,
      S_RAM_SETUP,
      S_RAM_ACCESS,
      S_SER,
      S_VGA,
      S_DONE
   } state_t;

   typedef enum logic [1:0] {
      T_RAM,
      T_SER_DATA,
      T_SER_STAT,
      T_VGA
   } tgt_t;

   if (RAM_WAIT > 15 || VGA_AW < 1 || VGA_AW >= ADDR_W || DATA_W < 8 ||
       TIMEOUT < 1 || TIMEOUT > 256 || VGA_BASE[VGA_AW-1:0] != '0) begin : g_param_check
      $error("mmio_bus_ctrl: illegal parameter set");
   end

   state_t     state_q;
   tgt_t       tgt_q;
   tgt_t       tgt_d;
   logic       we_q;
   logic [3:0] wait_q;

   always_comb begin
      tgt_d = T_RAM;
      if (addr_i == SER_DATA_ADDR) begin
         tgt_d = T_SER_DATA;
      end else if (addr_i == SER_STAT_ADDR) begin
         tgt_d = T_SER_STAT;
      end else if (addr_i[ADDR_W-1:VGA_AW] == VGA_BASE[ADDR_W-1:VGA_AW]) begin
         tgt_d = T_VGA;
      end
   end

`ifdef MMIO_TIMEOUT_EN
   logic [7:0] tmo_q;
`else
   assign err_o = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q             <= S_IDLE;
         tgt_q               <= T_RAM;
         we_q                <= 1'b0;
         wait_q              <= '0;
         rdata_o             <= '0;
         ack_o               <= 1'b0;
         busy_o              <= 1'b0;
         ram_enable_o        <= 1'b0;
         ram_readWrite_o     <= 1'b0;
         ram_address_o       <= '0;
         ram_dataWrite_o     <= '0;
         serial_enable_o     <= 1'b0;
         serial_readWrite_o  <= 1'b0;
         serial_fetch_data_o <= 1'b0;
         serial_dataWrite_o  <= '0;
         vga_enable_o        <= 1'b0;
         vga_readWrite_o     <= 1'b0;
         vga_address_o       <= '0;
         vga_dataWrite_o     <= '0;
`ifdef MMIO_TIMEOUT_EN
         err_o               <= 1'b0;
         tmo_q               <= '0;
`endif
      end else begin
         serial_enable_o     <= 1'b1;
         ack_o               <= 1'b0;
         serial_readWrite_o  <= 1'b0;
         serial_fetch_data_o <= 1'b0;
`ifdef MMIO_TIMEOUT_EN
         err_o               <= 1'b0;
`endif
         case (state_q)
            S_IDLE: begin
               if (req_i) begin
                  busy_o <= 1'b1;
                  we_q   <= we_i;
                  tgt_q  <= tgt_d;
                  case (tgt_d)
                     T_RAM: begin
                        state_q         <= S_RAM_SETUP;
                        ram_enable_o    <= 1'b1;
                        ram_readWrite_o <= 1'b0;
                        ram_address_o   <= addr_i;
                        ram_dataWrite_o <= wdata_i;
                     end
                     T_SER_DATA: begin
                        state_q             <= S_SER;
                        serial_readWrite_o  <= we_i;
                        serial_fetch_data_o <= ~we_i;
                        if (we_i) begin
                           serial_dataWrite_o <= wdata_i[7:0];
                        end
                     end
                     T_SER_STAT: begin
                        state_q <= S_SER;
                     end
                     default: begin
                        state_q         <= S_VGA;
                        vga_enable_o    <= 1'b1;
                        vga_readWrite_o <= we_i;
                        vga_address_o   <= addr_i[VGA_AW-1:0];
                        vga_dataWrite_o <= wdata_i;
`ifdef MMIO_TIMEOUT_EN
                        tmo_q           <= 8'(TIMEOUT - 1);
`endif
                     end
                  endcase
               end
            end

            S_RAM_SETUP: begin
               state_q         <= S_RAM_ACCESS;
               ram_readWrite_o <= we_q;
               wait_q          <= 4'(RAM_WAIT);
            end

            S_RAM_ACCESS: begin
               if (wait_q == 4'd0) begin
                  state_q         <= S_DONE;
                  ram_enable_o    <= 1'b0;
                  ram_readWrite_o <= 1'b0;
                  ack_o           <= 1'b1;
                  if (!we_q) begin
                     rdata_o <= ram_dataRead_i;
                  end
               end else begin
                  wait_q <= wait_q - 4'd1;
               end
            end

            S_SER: begin
               state_q <= S_DONE;
               ack_o   <= 1'b1;
               if (!we_q) begin
                  if (tgt_q == T_SER_DATA) begin
                     rdata_o <= DATA_W'(serial_dataRead_i);
                  end else begin
                     rdata_o <= DATA_W'({serial_receiveComplete_i, serial_sendComplete_i});
                  end
               end
            end

            S_VGA: begin
               if (vga_ready_i) begin
                  state_q         <= S_DONE;
                  vga_enable_o    <= 1'b0;
                  vga_readWrite_o <= 1'b0;
                  ack_o           <= 1'b1;
                  if (!we_q) begin
                     rdata_o <= vga_dataRead_i;
                  end
`ifdef MMIO_TIMEOUT_EN
               end else if (tmo_q == 8'd0) begin
                  // Abandoned access: report the error alongside the ack.
                  state_q         <= S_DONE;
                  vga_enable_o    <= 1'b0;
                  vga_readWrite_o <= 1'b0;
                  ack_o           <= 1'b1;
                  err_o           <= 1'b1;
                  if (!we_q) begin
                     rdata_o <= '1;
                  end
               end else begin
                  tmo_q <= tmo_q - 8'd1;
`endif
               end
            end

            S_DONE: begin
               state_q <= S_IDLE;
               busy_o  <= 1'b0;
            end

            default: begin
               state_q <= S_IDLE;
               busy_o  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mmio_bus_ctrl.sv
// tb_mmio_bus_ctrl: randomized transactions against a cycle-window reference model of mmio_bus_ctrl.
// Build with MMIO_TIMEOUT_EN defined to also exercise the VGA timeout path.
`timescale 1ns/1ps
module tb_mmio_bus_ctrl;

   localparam int RAM_WAIT = 1;
   localparam int TIMEOUT  = 8;
   localparam int MAX_CYC  = 44;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_i, we_i;
   logic [15:0] addr_i, wdata_i;
   logic [15:0] rdata_o;
   logic        ack_o, busy_o, err_o;
   logic        ram_enable_o, ram_readWrite_o;
   logic [15:0] ram_address_o, ram_dataWrite_o, ram_dataRead_i;
   logic        serial_enable_o, serial_readWrite_o, serial_fetch_data_o;
   logic [7:0]  serial_dataWrite_o, serial_dataRead_i;
   logic        serial_sendComplete_i, serial_receiveComplete_i;
   logic        vga_enable_o, vga_readWrite_o;
   logic [3:0]  vga_address_o;
   logic [15:0] vga_dataWrite_o, vga_dataRead_i;
   logic        vga_ready_i;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [15:0] exp_rdata = 16'h0000;

   always #5 clk = ~clk;

   mmio_bus_ctrl #(.RAM_WAIT(RAM_WAIT), .TIMEOUT(TIMEOUT)) dut (
      .clk                      (clk),
      .rst                      (rst),
      .req_i                    (req_i),
      .we_i                     (we_i),
      .addr_i                   (addr_i),
      .wdata_i                  (wdata_i),
      .rdata_o                  (rdata_o),
      .ack_o                    (ack_o),
      .busy_o                   (busy_o),
      .err_o                    (err_o),
      .ram_enable_o             (ram_enable_o),
      .ram_readWrite_o          (ram_readWrite_o),
      .ram_address_o            (ram_address_o),
      .ram_dataWrite_o          (ram_dataWrite_o),
      .ram_dataRead_i           (ram_dataRead_i),
      .serial_enable_o          (serial_enable_o),
      .serial_readWrite_o       (serial_readWrite_o),
      .serial_fetch_data_o      (serial_fetch_data_o),
      .serial_dataWrite_o       (serial_dataWrite_o),
      .serial_dataRead_i        (serial_dataRead_i),
      .serial_sendComplete_i    (serial_sendComplete_i),
      .serial_receiveComplete_i (serial_receiveComplete_i),
      .vga_enable_o             (vga_enable_o),
      .vga_readWrite_o          (vga_readWrite_o),
      .vga_address_o            (vga_address_o),
      .vga_dataWrite_o          (vga_dataWrite_o),
      .vga_dataRead_i           (vga_dataRead_i),
      .vga_ready_i              (vga_ready_i)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // 0 = RAM, 1 = serial data, 2 = serial status, 3 = VGA window
   function automatic int classify(input logic [15:0] a);
      if (a == 16'hBF00) return 1;
      if (a == 16'hBF01) return 2;
      if ((a >> 4) == 16'h0BE0) return 3;
      return 0;
   endfunction

   // Issues one access at the current negedge; vdelay < 0 means VGA ready never comes.
   task automatic run_txn(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                          input int vdelay);
      int          tgt, exp_lat, lat, bad_strobe, bad_bus, busy_cnt;
      logic        to_case;
      logic [4:0]  e_vec, a_vec;
      logic [15:0] ram_h [0:MAX_CYC];
      logic [15:0] vga_h [0:MAX_CYC];
      logic [7:0]  ser_h [0:MAX_CYC];
      logic [1:0]  st_h  [0:MAX_CYC];
      tgt     = classify(addr);
      to_case = (tgt == 3) && (vdelay < 0);
      if (tgt == 0)      exp_lat = 3 + RAM_WAIT;
      else if (tgt == 3) exp_lat = to_case ? TIMEOUT + 1 : vdelay + 2;
      else               exp_lat = 2;
      lat = 0; bad_strobe = 0; bad_bus = 0; busy_cnt = 0;
      ram_h[0] = 16'h0; vga_h[0] = 16'h0; ser_h[0] = 8'h0; st_h[0] = 2'b00;
      req_i = 1'b1; we_i = we; addr_i = addr; wdata_i = wdata; vga_ready_i = 1'b0;
      @(posedge clk);
      for (int k = 1; k <= MAX_CYC && lat == 0; k++) begin
         @(negedge clk);
         e_vec = {tgt == 0 && k <= RAM_WAIT + 2,
                  tgt == 0 && we && k >= 2 && k <= RAM_WAIT + 2,
                  tgt == 1 && we && k == 1,
                  tgt == 1 && !we && k == 1,
                  tgt == 3 && k < exp_lat};
         a_vec = {ram_enable_o, ram_readWrite_o, serial_readWrite_o, serial_fetch_data_o, vga_enable_o};
         if (a_vec != e_vec) bad_strobe++;
         busy_cnt += int'(busy_o);
         if (ram_enable_o && (ram_address_o != addr || ram_dataWrite_o != wdata)) bad_bus++;
         if (serial_readWrite_o && serial_dataWrite_o != wdata[7:0]) bad_bus++;
         if (vga_enable_o && (vga_address_o != addr[3:0] || vga_readWrite_o != we ||
                              vga_dataWrite_o != wdata)) bad_bus++;
         if (err_o != (to_case && ack_o)) bad_bus++;
         if (ack_o) begin
            lat = k;
            if (!we) begin
               case (tgt)
                  0:       exp_rdata = ram_h[k-1];
                  1:       exp_rdata = {8'h00, ser_h[k-1]};
                  2:       exp_rdata = {14'h0, st_h[k-1]};
                  default: exp_rdata = to_case ? 16'hFFFF : vga_h[k-1];
               endcase
            end
            chk("rdata", {16'h0, rdata_o}, {16'h0, exp_rdata});
            req_i = 1'b0; vga_ready_i = 1'b0;
         end else begin
            ram_h[k] = 16'($urandom);
            vga_h[k] = 16'($urandom);
            ser_h[k] = 8'($urandom);
            st_h[k]  = 2'($urandom);
            ram_dataRead_i           = ram_h[k];
            vga_dataRead_i           = vga_h[k];
            serial_dataRead_i        = ser_h[k];
            serial_receiveComplete_i = st_h[k][1];
            serial_sendComplete_i    = st_h[k][0];
            vga_ready_i = (tgt == 3) && !to_case && (k == vdelay + 1);
            addr_i  = 16'($urandom);
            wdata_i = 16'($urandom);
            we_i    = 1'($urandom);
         end
      end
      if (lat == 0) begin
         chk("ack_seen", 32'd0, 32'd1);
         req_i = 1'b0;
      end
      chk("ack_latency", lat, exp_lat);
      chk("strobe_windows", bad_strobe, 0);
      chk("bus_values", bad_bus, 0);
      chk("busy_cycles", busy_cnt, exp_lat);
      @(negedge clk);
      chk("idle_after_ack", {busy_o, ack_o, err_o, ram_enable_o, serial_readWrite_o,
                             serial_fetch_data_o, vga_enable_o}, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic ack_seen;
      int   cls;
      logic [15:0] a;
      req_i = 0; we_i = 0; addr_i = 0; wdata_i = 0; vga_ready_i = 0;
      ram_dataRead_i = 0; vga_dataRead_i = 0; serial_dataRead_i = 0;
      serial_sendComplete_i = 0; serial_receiveComplete_i = 0;
      rst = 1'b0;
      #1 rst = 1'b1;
      #2;
      chk("reset_ctl", {ack_o, busy_o, err_o, ram_enable_o, ram_readWrite_o, serial_enable_o,
                        serial_readWrite_o, serial_fetch_data_o, vga_enable_o, vga_readWrite_o}, 0);
      chk("reset_rdata", {16'h0, rdata_o}, 0);
      chk("reset_buses", {ram_address_o, ram_dataWrite_o}, 0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("serial_enable_after_reset", {31'h0, serial_enable_o}, 1);

      run_txn(1'b0, 16'h4000, 16'h1234, 0);
      run_txn(1'b1, 16'h0010, 16'h00FF, 0);
      run_txn(1'b1, 16'hBF00, 16'h1241, 0);
      run_txn(1'b0, 16'hBF01, 16'h0000, 0);
      run_txn(1'b0, 16'hBF00, 16'h0000, 0);
      run_txn(1'b1, 16'hBF01, 16'hFFFF, 0);
      run_txn(1'b0, 16'hBE05, 16'h0000, 3);
      run_txn(1'b0, 16'hBE0A, 16'h0000, 0);
      run_txn(1'b1, 16'hBE0F, 16'hC0DE, 2);
      run_txn(1'b0, 16'hBE10, 16'h0000, 0);
      run_txn(1'b0, 16'hBDFF, 16'h0000, 0);

      // Abort a RAM read mid-access with reset.
      req_i = 1'b1; we_i = 1'b0; addr_i = 16'h4000; wdata_i = 16'h1234;
      ram_dataRead_i = 16'hA5A5;
      @(posedge clk);
      @(negedge clk);
      @(negedge clk);
      chk("pre_abort_ram_en", {31'h0, ram_enable_o}, 1);
      #1 rst = 1'b1;
      #1;
      chk("abort_strobes", {ram_enable_o, ram_readWrite_o, vga_enable_o, serial_readWrite_o,
                            serial_fetch_data_o}, 0);
      chk("abort_status", {ack_o, busy_o, err_o, serial_enable_o}, 0);
      chk("abort_rdata", {16'h0, rdata_o}, 0);
      exp_rdata = 16'h0000;
      req_i = 1'b0;
      ack_seen = 1'b0;
      repeat (3) begin @(negedge clk); ack_seen |= ack_o; end
      rst = 1'b0;
      repeat (2) begin @(negedge clk); ack_seen |= ack_o; end
      chk("no_ack_after_abort", {31'h0, ack_seen}, 0);
      run_txn(1'b0, 16'h4000, 16'h1234, 0);

`ifdef MMIO_TIMEOUT_EN
      run_txn(1'b0, 16'hBE03, 16'h0000, -1);
      run_txn(1'b1, 16'hBE04, 16'h5555, -1);
      run_txn(1'b0, 16'hBE03, 16'h0000, 1);
`endif

      for (int i = 0; i < 150; i++) begin
         cls = int'($urandom_range(0, 4));
         case (cls)
            0:       a = 16'($urandom);
            1:       a = 16'hBF00;
            2:       a = 16'hBF01;
            3:       a = {12'hBE0, 4'($urandom)};
            default: a = {8'hBE, 8'($urandom)};
         endcase
         run_txn(1'($urandom), a, 16'($urandom), int'($urandom_range(0, 5)));
         if ($urandom_range(0, 3) == 0) begin
            repeat (int'($urandom_range(1, 3))) @(negedge clk);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mmio_bus_ctrl.md
Name: mmio_bus_ctrl

Overview:
- Sequential, parametrised memory-mapped bus controller between the CPU memory stage and the RAM, serial and VGA ports.
- Registers each request and decodes it to one target.
- Runs a per-target access FSM with programmable RAM wait states and a VGA ready handshake.
- Returns registered read data with a one-cycle ack; busy_o stalls the pipeline meanwhile.

Parameters:
- ADDR_W, 16, address width
- DATA_W, 16, data width
- SER_DATA_ADDR, 16'hBF00, serial data register address
- SER_STAT_ADDR, 16'hBF01, serial status register address
- VGA_BASE, 16'hBE00, VGA window base; must be aligned to 2^VGA_AW
- VGA_AW, 4, VGA window address bits (window = 2^VGA_AW words)
- RAM_WAIT, 1, extra RAM access cycles (0..15)
- TIMEOUT, 255, VGA handshake timeout in cycles (only with MMIO_TIMEOUT_EN)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- req_i  in  1  access request
- we_i  in  1  1=write, 0=read
- addr_i  in  ADDR_W  access address
- wdata_i  in  DATA_W  write data
- rdata_o  out  DATA_W  read data, valid with ack_o and held until the next ack
- ack_o  out  1  one-cycle completion pulse
- busy_o  out  1  controller not idle
- err_o  out  1  with ack_o: access timed out (MMIO_TIMEOUT_EN only)
- ram_enable_o  out  1  RAM chip enable
- ram_readWrite_o  out  1  1=write strobe
- ram_address_o  out  ADDR_W  RAM address
- ram_dataWrite_o  out  DATA_W  RAM write data
- ram_dataRead_i  in  DATA_W  RAM read data
- serial_enable_o  out  1  serial port enable
- serial_readWrite_o  out  1  1=write byte
- serial_fetch_data_o  out  1  pops the receive byte
- serial_dataWrite_o  out  8  byte to send
- serial_dataRead_i  in  8  received byte
- serial_sendComplete_i  in  1  transmitter idle
- serial_receiveComplete_i  in  1  byte available
- vga_enable_o  out  1  VGA access strobe
- vga_readWrite_o  out  1  1=write
- vga_address_o  out  VGA_AW  word offset in window
- vga_dataWrite_o  out  DATA_W  VGA write data
- vga_dataRead_i  in  DATA_W  VGA read data
- vga_ready_i  in  1  VGA access complete

Behaviour:
- Reset, asynchronous: state IDLE, all outputs 0 including rdata_o, ack_o, busy_o and err_o; no ack is issued for an aborted access.
- serial_enable_o is 0 in reset and 1 thereafter.
- Accept: in IDLE, req_i=1 at edge T latches addr, we and wdata; busy_o=1 from T+1 until the ack cycle inclusive.
- req_i is ignored while busy; the upstream holds req_i until ack_o. The earliest next accept is the edge after the ack cycle.
- Decode priority: SER_DATA_ADDR, then SER_STAT_ADDR, then VGA window (addr[ADDR_W-1:VGA_AW] == VGA_BASE[ADDR_W-1:VGA_AW]), else RAM.
- States: IDLE, RAM_SETUP, RAM_ACCESS, SER, VGA, DONE.
- RAM_SETUP, 1 cycle: ram_enable_o=1, address and data driven, ram_readWrite_o=0.
- RAM_ACCESS, RAM_WAIT+1 cycles, down-counter: ram_readWrite_o=we. A read samples ram_dataRead_i in its last cycle.
- RAM timing: ack in cycle T+3+RAM_WAIT. The address is stable through SETUP and ACCESS; ram_readWrite_o is 0 in DONE.
- SER data write: serial_readWrite_o=1 and serial_dataWrite_o=wdata[7:0] for exactly 1 cycle.
- SER data read: serial_fetch_data_o=1 for exactly 1 cycle; rdata = {0, serial_dataRead_i} sampled in that cycle.
- SER status read: rdata = {0, receiveComplete, sendComplete} sampled in the SER cycle.
- SER status write: no strobe; acked normally.
- SER timing: ack at T+2.
- VGA: vga_enable_o=1 with address = addr[VGA_AW-1:0] until the first cycle vga_ready_i=1. Read data is sampled in that cycle; then DONE.
- VGA ready at entry: if vga_ready_i=1 in the first VGA cycle, ack at T+2.
- DONE, 1 cycle: ack_o=1, all strobes 0; next state is IDLE.
- Only one target strobe is active in any cycle.
- Write accesses leave rdata_o unchanged.

Optional Feature:
- MMIO_TIMEOUT_EN defined: an 8-bit counter runs in VGA state. If TIMEOUT cycles elapse without vga_ready_i, the access is abandoned: DONE with ack_o=1, err_o=1, rdata = all ones for reads.
- MMIO_TIMEOUT_EN undefined: VGA waits indefinitely; err_o is tied 0 and the TIMEOUT parameter is unused.

Test Plan:
- RAM_WAIT=1, read 16'h1234 at 16'h4000 (ram_dataRead_i=16'hA5A5) -> ram_enable_o high cycles T+1..T+3, ram_readWrite_o 0 throughout, ack at T+4, rdata_o=16'hA5A5.
- RAM write 16'h00FF at 16'h0010 -> ram_readWrite_o=1 only in cycles T+2..T+3, ram_dataWrite_o=16'h00FF, ack at T+4, rdata_o unchanged.
- Serial: write 16'h1241 to BF00 -> serial_dataWrite_o=8'h41 with a one-cycle strobe; read BF01 with receive=1, send=0 -> rdata_o=16'h0002; read BF00 with byte 8'h7E -> single fetch pulse, rdata_o=16'h007E.
- VGA read at 16'hBE05 with ready delayed 3 cycles -> vga_address_o=4'h5, enable held 4 cycles, ack on the following cycle; address 16'hBE10 routes to RAM.
- Assert rst during RAM_ACCESS -> all strobes drop immediately, no ack; a fresh read after release completes normally.
- With MMIO_TIMEOUT_EN and TIMEOUT=8, VGA read with ready never asserted -> ack_o and err_o together 8 cycles into VGA, rdata_o=16'hFFFF.
